// File: rtl/traffic_light_monitor_if.sv
// Observed controller lamps, tick and clear in; decoded phase,
// sticky error flags and cycle count out.
interface traffic_light_monitor_if;
    logic       tick_1hz;
    logic       ns_g;
    logic       ns_y;
    logic       ns_r;
    logic       ew_g;
    logic       ew_y;
    logic       ew_r;
    logic       clr_err;
    logic [2:0] phase;
    logic       err_illegal;
    logic       err_seq;
    logic       err_timing;
    logic [7:0] cycle_cnt;

    modport master (
        output tick_1hz,
        output ns_g,
        output ns_y,
        output ns_r,
        output ew_g,
        output ew_y,
        output ew_r,
        output clr_err,
        input  phase,
        input  err_illegal,
        input  err_seq,
        input  err_timing,
        input  cycle_cnt
    );

    modport slave (
        input  tick_1hz,
        input  ns_g,
        input  ns_y,
        input  ns_r,
        input  ew_g,
        input  ew_y,
        input  ew_r,
        input  clr_err,
        output phase,
        output err_illegal,
        output err_seq,
        output err_timing,
        output cycle_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for a two-way traffic light controller: decodes
// the lamp pattern, tracks phase order and duration, flags faults.
module traffic_light_monitor #(
    parameter int G_TICKS = 5,
    parameter int Y_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_light_monitor_if.slave mon
);

    localparam logic [2:0] S_SYNC = 3'd0;
    localparam logic [2:0] S_NSG  = 3'd1;
    localparam logic [2:0] S_NSY  = 3'd2;
    localparam logic [2:0] S_EWG  = 3'd3;
    localparam logic [2:0] S_EWY  = 3'd4;

    localparam logic [3:0] G_EXP   = 4'(G_TICKS);
    localparam logic [3:0] Y_EXP   = 4'(Y_TICKS);
    localparam logic [3:0] CNT_MAX = 4'hF;
    localparam logic [7:0] CYC_MAX = 8'hFF;

    logic [2:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic       chk_q, chk_d;
    logic [7:0] cyc_q, cyc_d;
    logic       ill_q, ill_d;
    logic       seq_q, seq_d;
    logic       tim_q, tim_d;

    logic [5:0] lamps;
    logic [2:0] pattern;
    logic       legal;
    logic [2:0] succ;
    logic [3:0] exp_ticks;
    logic [3:0] tick_in;
    logic [3:0] tick_inc;
    logic       new_ill;
    logic       new_seq;
    logic       new_tim;

    assign lamps = {mon.ns_g, mon.ns_y, mon.ns_r,
                    mon.ew_g, mon.ew_y, mon.ew_r};

    // Only the four exact one-green/one-red style patterns are legal.
    always_comb begin
        pattern = S_SYNC;
        unique case (lamps)
            6'b100001: pattern = S_NSG;
            6'b010001: pattern = S_NSY;
            6'b001100: pattern = S_EWG;
            6'b001010: pattern = S_EWY;
            default:   pattern = S_SYNC;
        endcase
    end

    assign legal = (pattern != S_SYNC);

    always_comb begin
        succ = S_NSG;
        unique case (state_q)
            S_NSG:   succ = S_NSY;
            S_NSY:   succ = S_EWG;
            S_EWG:   succ = S_EWY;
            default: succ = S_NSG;
        endcase
    end

    assign exp_ticks = ((state_q == S_NSG) || (state_q == S_EWG))
                     ? G_EXP : Y_EXP;

    assign tick_in  = {3'b000, mon.tick_1hz};
    assign tick_inc = (tick_q == CNT_MAX) ? CNT_MAX : tick_q + tick_in;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        chk_d   = chk_q;
        cyc_d   = cyc_q;
        new_ill = 1'b0;
        new_seq = 1'b0;
        new_tim = 1'b0;
        if (state_q == S_SYNC) begin
            if (legal) begin
                state_d = pattern;
                chk_d   = 1'b0;
                tick_d  = tick_in;
            end else begin
                tick_d  = 4'd0;
            end
        end else if (!legal) begin
            new_ill = 1'b1;
            state_d = S_SYNC;
            chk_d   = 1'b0;
            tick_d  = 4'd0;
        end else if (pattern == state_q) begin
            tick_d = tick_inc;
            if (chk_q && (tick_inc > exp_ticks)) begin
                new_tim = 1'b1;
            end
        end else if (pattern == succ) begin
            if (chk_q && (tick_q != exp_ticks)) begin
                new_tim = 1'b1;
            end
            if ((state_q == S_EWY) && (cyc_q != CYC_MAX)) begin
                cyc_d = cyc_q + 8'd1;
            end
            state_d = pattern;
            chk_d   = 1'b1;
            tick_d  = tick_in;
        end else begin
            // Out-of-order jump: resync to it, duration unknown.
            new_seq = 1'b1;
            state_d = pattern;
            chk_d   = 1'b0;
            tick_d  = tick_in;
        end
    end

    assign ill_d = (ill_q & ~mon.clr_err) | new_ill;
    assign seq_d = (seq_q & ~mon.clr_err) | new_seq;
    assign tim_d = (tim_q & ~mon.clr_err) | new_tim;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_SYNC;
            tick_q  <= 4'd0;
            chk_q   <= 1'b0;
            cyc_q   <= 8'd0;
            ill_q   <= 1'b0;
            seq_q   <= 1'b0;
            tim_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            chk_q   <= chk_d;
            cyc_q   <= cyc_d;
            ill_q   <= ill_d;
            seq_q   <= seq_d;
            tim_q   <= tim_d;
        end
    end

    assign mon.phase       = state_q;
    assign mon.err_illegal = ill_q;
    assign mon.err_seq     = seq_q;
    assign mon.err_timing  = tim_q;
    assign mon.cycle_cnt   = cyc_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scenarios plus random lamp traffic, each cycle compared
// against a phase/duration reference model of the monitor rules.
module tb_traffic_light_monitor;

    localparam int G_T = 5;
    localparam int Y_T = 2;

    logic clk;
    logic reset;

    traffic_light_monitor_if mon_if ();

    traffic_light_monitor #(
        .G_TICKS(G_T),
        .Y_TICKS(Y_T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .mon  (mon_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_ph;
    int m_ticks;
    bit m_chk;
    int m_cyc;
    bit m_ei;
    bit m_es;
    bit m_et;

    int ctl_ph;
    int ctl_cnt;
    int ctl_cycles;
    int tick_ph;

    function automatic logic [5:0] lamps_of(input int ph);
        case (ph)
            1:       return 6'b100001;
            2:       return 6'b010001;
            3:       return 6'b001100;
            4:       return 6'b001010;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] l);
        for (int p = 1; p <= 4; p++) begin
            if (lamps_of(p) == l) return p;
        end
        return 0;
    endfunction

    function automatic int dur(input int ph);
        return (ph == 1 || ph == 3) ? G_T : Y_T;
    endfunction

    function automatic void model_reset();
        m_ph = 0; m_ticks = 0; m_chk = 0; m_cyc = 0;
        m_ei = 0; m_es = 0; m_et = 0;
    endfunction

    function automatic void model_step(input bit t, input logic [5:0] l,
                                       input bit clr);
        int p;
        bit ni, ns, nt;
        p = classify(l);
        ni = 0; ns = 0; nt = 0;
        if (m_ph == 0) begin
            if (p != 0) begin
                m_ph = p; m_chk = 0; m_ticks = int'(t);
            end
        end else if (p == 0) begin
            ni = 1; m_ph = 0; m_chk = 0; m_ticks = 0;
        end else if (p == m_ph) begin
            m_ticks = (m_ticks + int'(t) > 15) ? 15 : m_ticks + int'(t);
            if (m_chk && m_ticks > dur(m_ph)) nt = 1;
        end else if (p == m_ph % 4 + 1) begin
            if (m_chk && m_ticks != dur(m_ph)) nt = 1;
            if (m_ph == 4 && m_cyc < 255) m_cyc++;
            m_ph = p; m_chk = 1; m_ticks = int'(t);
        end else begin
            ns = 1; m_ph = p; m_chk = 0; m_ticks = int'(t);
        end
        m_ei = (m_ei && !clr) || ni;
        m_es = (m_es && !clr) || ns;
        m_et = (m_et && !clr) || nt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("phase", 32'(mon_if.phase), 32'(m_ph));
        chk("err_illegal", 32'(mon_if.err_illegal), 32'(m_ei));
        chk("err_seq", 32'(mon_if.err_seq), 32'(m_es));
        chk("err_timing", 32'(mon_if.err_timing), 32'(m_et));
        chk("cycle_cnt", 32'(mon_if.cycle_cnt), 32'(m_cyc));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_phase"}, 32'(mon_if.phase), 0);
        chk({tag, "_ill"}, 32'(mon_if.err_illegal), 0);
        chk({tag, "_seq"}, 32'(mon_if.err_seq), 0);
        chk({tag, "_tim"}, 32'(mon_if.err_timing), 0);
        chk({tag, "_cyc"}, 32'(mon_if.cycle_cnt), 0);
    endtask

    task automatic drive(input bit t, input logic [5:0] l, input bit clr);
        mon_if.tick_1hz = t;
        {mon_if.ns_g, mon_if.ns_y, mon_if.ns_r,
         mon_if.ew_g, mon_if.ew_y, mon_if.ew_r} = l;
        mon_if.clr_err = clr;
        @(posedge clk);
        model_step(t, l, clr);
        #1;
        chk_model();
    endtask

    // One clock of a well-behaved controller sharing the tick.
    task automatic step_ctrl(input int period, input int gdur,
                             input bit clr);
        bit t;
        int need;
        t = (tick_ph == period - 1);
        tick_ph = (tick_ph + 1) % period;
        drive(t, lamps_of(ctl_ph), clr);
        if (t) begin
            ctl_cnt++;
            need = (ctl_ph == 1 || ctl_ph == 3) ? gdur : Y_T;
            if (ctl_cnt >= need) begin
                if (ctl_ph == 4) ctl_cycles++;
                ctl_ph = ctl_ph % 4 + 1;
                ctl_cnt = 0;
            end
        end
    endtask

    task automatic run_until(input int target, input int period,
                             input int gdur);
        int n;
        n = 0;
        do begin
            step_ctrl(period, gdur, 1'b0);
            n++;
        end while (ctl_ph != target && n < 400);
        if (ctl_ph != target) begin
            checks++;
            errors++;
            $error("FAIL run_until: observed phase %0d expected %0d",
                   ctl_ph, target);
        end
    endtask

    task automatic ctl_restart(input int ph);
        ctl_ph = ph; ctl_cnt = 0; tick_ph = 0;
    endtask

    task automatic do_reset();
        #3 reset = 1'b0;
        #1;
        model_reset();
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        int c0, nt, len, r, p, guard;
        bit t, clr;
        logic [5:0] l;
        reset = 1'b1;
        mon_if.tick_1hz = 0;
        mon_if.clr_err = 0;
        {mon_if.ns_g, mon_if.ns_y, mon_if.ns_r,
         mon_if.ew_g, mon_if.ew_y, mon_if.ew_r} = 6'b0;
        model_reset();
        ctl_cycles = 0;
        #2 reset = 1'b0;
        #1;
        chk_all_zero("por");
        @(posedge clk);
        #2 reset = 1'b1;

        // Correct controller, tick every 10 clocks.
        ctl_restart(1);
        c0 = ctl_cycles;
        for (int i = 0; i < 2001; i++) step_ctrl(10, G_T, 1'b0);
        chk("run_cyc", 32'(mon_if.cycle_cnt), 32'(ctl_cycles - c0));
        chk("run_tim", 32'(mon_if.err_timing), 0);
        chk("run_seq", 32'(mon_if.err_seq), 0);
        chk("run_ill", 32'(mon_if.err_illegal), 0);

        // Short green: NSG for only 4 ticks.
        run_until(2, 10, G_T);
        run_until(1, 10, G_T);
        run_until(2, 10, 4);
        step_ctrl(10, G_T, 1'b0);
        chk("short_tim", 32'(mon_if.err_timing), 1);
        chk("short_phase", 32'(mon_if.phase), 2);
        step_ctrl(10, G_T, 1'b1);
        chk("short_clr", 32'(mon_if.err_timing), 0);

        // Overlong green: 6th tick must flag.
        run_until(1, 10, G_T);
        nt = 0;
        guard = 0;
        while (nt < 6 && guard < 200) begin
            t = (tick_ph == 9);
            tick_ph = (tick_ph + 1) % 10;
            drive(t, lamps_of(1), 1'b0);
            guard++;
            if (t) begin
                nt++;
                if (nt == 5) chk("over5", 32'(mon_if.err_timing), 0);
                if (nt == 6) chk("over6", 32'(mon_if.err_timing), 1);
            end
        end
        ctl_restart(2);
        for (int i = 0; i < 60; i++) step_ctrl(10, G_T, 1'b0);

        // Illegal pattern then resync.
        drive(1'b0, lamps_of(ctl_ph), 1'b1);
        l = 6'b100100;
        drive(1'b0, l, 1'b0);
        chk("ill_flag", 32'(mon_if.err_illegal), 1);
        chk("ill_phase", 32'(mon_if.phase), 0);
        drive(1'b0, lamps_of(1), 1'b0);
        chk("resync_phase", 32'(mon_if.phase), 1);
        chk("resync_seq", 32'(mon_if.err_seq), 0);
        chk("resync_tim", 32'(mon_if.err_timing), 0);

        // Skip NSY: NSG straight to EWG.
        drive(1'b0, lamps_of(3), 1'b0);
        chk("skip_seq", 32'(mon_if.err_seq), 1);
        chk("skip_phase", 32'(mon_if.phase), 3);
        drive(1'b0, lamps_of(3), 1'b1);
        chk("clr_ill", 32'(mon_if.err_illegal), 0);
        chk("clr_seq", 32'(mon_if.err_seq), 0);
        chk("clr_tim", 32'(mon_if.err_timing), 0);
        ctl_restart(3);
        for (int i = 0; i < 300; i++) step_ctrl(10, G_T, 1'b0);

        // Random lamp traffic against the model.
        for (int s = 0; s < 60; s++) begin
            r = $urandom_range(0, 9);
            if (r < 6 && m_ph != 0) p = m_ph % 4 + 1;
            else p = $urandom_range(1, 4);
            if (r >= 8) l = 6'($urandom_range(0, 63));
            else l = lamps_of(p);
            len = $urandom_range(1, 30);
            for (int i = 0; i < len; i++) begin
                t = ($urandom_range(0, 4) == 0);
                clr = ($urandom_range(0, 40) == 0);
                drive(t, l, clr);
            end
        end

        // Saturation over 300 cycles, then async reset mid-phase.
        do_reset();
        ctl_restart(1);
        c0 = ctl_cycles;
        guard = 0;
        while (ctl_cycles - c0 < 300 && guard < 12000) begin
            step_ctrl(2, G_T, 1'b0);
            guard++;
        end
        step_ctrl(2, G_T, 1'b0);
        chk("sat_cyc", 32'(mon_if.cycle_cnt), 255);
        chk("sat_tim", 32'(mon_if.err_timing), 0);
        for (int i = 0; i < 7; i++) step_ctrl(2, G_T, 1'b0);
        do_reset();
        ctl_restart(2);
        for (int i = 0; i < 100; i++) step_ctrl(10, G_T, 1'b0);
        chk("post_seq", 32'(mon_if.err_seq), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
